// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_ctrl
// Brief    : Fetch-PC sequencing controller for the P7 MIPS core. Selects the
//            PC source, owns the mult/div busy countdown and the eret/EPC
//            interlock. Optional macro PC_STALL_PERF_EN adds stall/redirect
//            performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic        exc_req,
    input  logic        eret_d,
    input  logic        mtc0_epc_e,
    input  logic        mtc0_epc_m,
    input  logic        md_start_e,
    input  logic        md_is_div_e,
    input  logic        md_use_d,
    input  logic        redirect_d,
    input  logic        data_stall,
`ifdef PC_STALL_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redir_cnt,
`endif
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        stall_fd,
    output logic        flush_d,
    output logic        md_busy,
    output logic [1:0]  state_o
);

    localparam logic [1:0] c_ST_RUN       = 2'd0;
    localparam logic [1:0] c_ST_MD_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_ERET_WAIT = 2'd2;
    localparam logic [1:0] c_ST_EXC       = 2'd3;

    localparam logic [1:0] c_SEL_SEQ = 2'd0;
    localparam logic [1:0] c_SEL_NPC = 2'd1;
    localparam logic [1:0] c_SEL_EPC = 2'd2;
    localparam logic [1:0] c_SEL_EXC = 2'd3;

    localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_md_cnt;
    logic             w_md_busy;
    logic             w_md_hold;
    logic             w_eret_hold;
    logic             w_hold;
    logic             w_exc;

    assign w_md_busy   = (r_md_cnt != '0) | md_start_e;
    assign w_md_hold   = md_use_d & w_md_busy;
    assign w_eret_hold = eret_d & (mtc0_epc_e | mtc0_epc_m);
    assign w_hold      = data_stall | w_md_hold | w_eret_hold;
    assign w_exc       = int_req | exc_req;

    // Countdown keeps running through exceptions; last issue reloads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (md_start_e) begin
            r_md_cnt <= md_is_div_e ? c_DIV_LOAD : c_MULT_LOAD;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = c_ST_RUN;
        if (w_exc) begin
            w_state_nxt = c_ST_EXC;
        end else if (w_eret_hold) begin
            w_state_nxt = c_ST_ERET_WAIT;
        end else if (w_md_hold) begin
            w_state_nxt = c_ST_MD_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Eret interlock and data/MD holds share the same stall-and-bubble output.
    always_comb begin
        pc_we    = 1'b0;
        pc_sel   = c_SEL_SEQ;
        stall_fd = 1'b0;
        flush_d  = 1'b0;
        if (!reset) begin
            if (w_exc) begin
                pc_we   = 1'b1;
                pc_sel  = c_SEL_EXC;
                flush_d = 1'b1;
            end else if (w_hold) begin
                stall_fd = 1'b1;
                flush_d  = 1'b1;
            end else if (eret_d) begin
                pc_we   = 1'b1;
                pc_sel  = c_SEL_EPC;
                flush_d = 1'b1;
            end else if (redirect_d) begin
                pc_we  = 1'b1;
                pc_sel = c_SEL_NPC;
            end else begin
                pc_we = 1'b1;
            end
        end
    end

    assign md_busy = ~reset & w_md_busy;
    assign state_o = reset ? c_ST_RUN : r_state;

`ifdef PC_STALL_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_redir_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall_cnt <= '0;
            r_perf_redir_cnt <= '0;
        end else begin
            if (stall_fd) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (pc_we && (pc_sel != c_SEL_SEQ)) begin
                r_perf_redir_cnt <= r_perf_redir_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_redir_cnt = r_perf_redir_cnt;
`endif

endmodule
`default_nettype wire
